bj_key_decoder: RTL and testbench

PS/2 scan-code decoder for the blackjack keyboard front end. Consumes the byte stream from `PS2_Controller` (`received_data` / `received_data_en`) and tracks make, break (`F0`) and extended (`E0`) prefix sequences. Produces debounced game commands for the blackjack FSM: HIT (`H`), STAND (`S`) and DEAL (`D`). Typematic repeats are suppressed, and a held level per key is provided for LED display.

---
 rtl/bj_key_decoder.sv | 103 ++++++++++
 tb/tb_bj_key_decoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bj_key_decoder.sv
// PS/2 scan-code decoder: tracks F0/E0 prefixes and turns H/S/D make/break codes
// into one-cycle command pulses and per-key held levels, with typematic suppression.
module bj_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter logic [7:0]  CODE_HIT       = 8'h33,
  parameter logic [7:0]  CODE_STAND     = 8'h1B,
  parameter logic [7:0]  CODE_DEAL      = 8'h23
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       hit_pulse,
  output logic       stand_pulse,
  output logic       deal_pulse,
  output logic       hit_held,
  output logic       stand_held,
  output logic       deal_held,
  output logic [7:0] last_code,
  output logic       prefix_timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [2:0]      r_held, w_held_next;   // {deal, stand, hit}
  logic [2:0]      r_pulse, w_pulse_next;
  logic [7:0]      r_last_code, w_last_code_next;
  logic            r_timeout, w_timeout;
  logic [2:0]      w_match;
  logic            w_make, w_brk, w_resp;

  always_comb begin
    w_match      = {received_data == CODE_DEAL, received_data == CODE_STAND,
                    received_data == CODE_HIT};
    w_resp       = (received_data == 8'hAA) || (received_data == 8'hFA) ||
                   (received_data == 8'hFE) || (received_data == 8'hEE);
    w_state_next = r_state;
    w_make       = 1'b0;
    w_brk        = 1'b0;
    w_timeout    = 1'b0;

    if (received_data_en) begin
      unique case (r_state)
        StIdle: begin
          if (received_data == 8'hF0)      w_state_next = StBrk;
          else if (received_data == 8'hE0) w_state_next = StExt;
          else if (!w_resp)                w_make = 1'b1;
        end
        StBrk: begin
          w_brk        = 1'b1;
          w_state_next = StIdle;
        end
        StExt:    w_state_next = (received_data == 8'hF0) ? StExtBrk : StIdle;
        StExtBrk: w_state_next = StIdle;
      endcase
    end else if (r_state != StIdle && r_cnt == CntLast) begin
      // A strobe on the expiry cycle takes the branch above instead.
      w_state_next = StIdle;
      w_timeout    = 1'b1;
    end

    if (received_data_en || r_state == StIdle) w_cnt_next = '0;
    else if (r_cnt != CntLast)                 w_cnt_next = r_cnt + CntW'(1);
    else                                       w_cnt_next = r_cnt;

    w_pulse_next     = w_make ? (w_match & ~r_held) : 3'b000;
    w_held_next      = (r_held | (w_make ? w_match : 3'b000)) & ~(w_brk ? w_match : 3'b000);
    w_last_code_next = w_make ? received_data : r_last_code;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_held      <= 3'b000;
      r_pulse     <= 3'b000;
      r_last_code <= 8'h00;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_held      <= w_held_next;
      r_pulse     <= w_pulse_next;
      r_last_code <= w_last_code_next;
      r_timeout   <= w_timeout;
    end
  end

  assign hit_pulse      = r_pulse[0];
  assign stand_pulse    = r_pulse[1];
  assign deal_pulse     = r_pulse[2];
  assign hit_held       = r_held[0];
  assign stand_held     = r_held[1];
  assign deal_held      = r_held[2];
  assign last_code      = r_last_code;
  assign prefix_timeout = r_timeout;

endmodule

// File: tb/tb_bj_key_decoder.sv
// Directed bench for bj_key_decoder: byte sequences with hand-computed pulse/held/last_code.
module tb_bj_key_decoder;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] data;
  logic       en;
  logic       hit_pulse, stand_pulse, deal_pulse;
  logic       hit_held, stand_held, deal_held;
  logic [7:0] last_code;
  logic       prefix_timeout;

  int vectors = 0;
  int miscompares = 0;
  int cnt;

  bj_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50        (clk),
    .resetn          (resetn),
    .received_data   (data),
    .received_data_en(en),
    .hit_pulse       (hit_pulse),
    .stand_pulse     (stand_pulse),
    .deal_pulse      (deal_pulse),
    .hit_held        (hit_held),
    .stand_held      (stand_held),
    .deal_held       (deal_held),
    .last_code       (last_code),
    .prefix_timeout  (prefix_timeout)
  );

  always #10 clk = ~clk;

  // Called at a negedge; strobes the byte at the next posedge and returns at the
  // following negedge, where that byte's registered result is visible.
  task automatic send(input logic [7:0] b);
    data = b;
    en   = 1'b1;
    @(negedge clk);
    en   = 1'b0;
    data = 8'hXX;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pulses/held ordered {hit, stand, deal}
  task automatic chk_all(input string tag, input logic [2:0] p, input logic [2:0] h,
                         input logic [7:0] lc, input logic pt);
    chk({tag, ".pulse"}, {5'd0, hit_pulse, stand_pulse, deal_pulse}, {5'd0, p});
    chk({tag, ".held"}, {5'd0, hit_held, stand_held, deal_held}, {5'd0, h});
    chk({tag, ".last"}, last_code, lc);
    chk({tag, ".tmo"}, {7'd0, prefix_timeout}, {7'd0, pt});
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b0;
    data   = 8'h00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    chk_all("reset", 3'b000, 3'b000, 8'h00, 1'b0);

    // Basic make/break, back-to-back strobes
    send(8'h33); chk_all("hit_make", 3'b100, 3'b100, 8'h33, 1'b0);
    send(8'hF0); chk_all("hit_f0", 3'b000, 3'b100, 8'h33, 1'b0);
    send(8'h33); chk_all("hit_brk", 3'b000, 3'b000, 8'h33, 1'b0);
    @(negedge clk); chk_all("hit_idle", 3'b000, 3'b000, 8'h33, 1'b0);

    // Typematic STAND
    send(8'h1B); chk_all("stand_make", 3'b010, 3'b010, 8'h1B, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(8'h1B); chk_all("stand_rpt", 3'b000, 3'b010, 8'h1B, 1'b0);
    end
    send(8'hF0); send(8'h1B); chk_all("stand_brk", 3'b000, 3'b000, 8'h1B, 1'b0);

    // Extended and controller-response bytes are ignored
    do_reset();
    chk_all("reset2", 3'b000, 3'b000, 8'h00, 1'b0);
    send(8'hE0); send(8'h33); chk_all("ext_make", 3'b000, 3'b000, 8'h00, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h33); chk_all("ext_brk", 3'b000, 3'b000, 8'h00, 1'b0);
    send(8'hAA); chk_all("resp_aa", 3'b000, 3'b000, 8'h00, 1'b0);
    send(8'hFA); chk_all("resp_fa", 3'b000, 3'b000, 8'h00, 1'b0);
    send(8'h42); chk_all("unmatched", 3'b000, 3'b000, 8'h42, 1'b0);

    // Overlapping HIT and DEAL
    send(8'h33); chk_all("ov_hit", 3'b100, 3'b100, 8'h33, 1'b0);
    send(8'h23); chk_all("ov_deal", 3'b001, 3'b101, 8'h23, 1'b0);
    send(8'hF0); send(8'h33); chk_all("ov_hit_brk", 3'b000, 3'b001, 8'h23, 1'b0);
    send(8'h23); chk_all("ov_deal_rpt", 3'b000, 3'b001, 8'h23, 1'b0);
    send(8'hF0); send(8'h23); chk_all("ov_deal_brk", 3'b000, 3'b000, 8'h23, 1'b0);

    // Prefix timeout: F0 then silence; timeout pulse expected after T cycles in BRK
    send(8'hF0);
    cnt = 0;
    for (int i = 1; i <= T + 2; i++) begin
      if (prefix_timeout) begin
        cnt++;
        chk("tmo_cycle", 8'(i), 8'(T + 1));
      end
      @(negedge clk);
    end
    chk("tmo_count", 8'(cnt), 8'd1);
    send(8'h33); chk_all("tmo_then_make", 3'b100, 3'b100, 8'h33, 1'b0);

    // Strobe exactly on the expiry cycle: processed as a break, no timeout
    send(8'hF0);
    repeat (T - 1) @(negedge clk);
    send(8'h33); chk_all("exp_brk", 3'b000, 3'b000, 8'h33, 1'b0);
    cnt = 0;
    for (int i = 0; i < T + 2; i++) begin
      if (prefix_timeout) cnt++;
      @(negedge clk);
    end
    chk("exp_no_tmo", 8'(cnt), 8'd0);
    send(8'h33); chk_all("exp_then_make", 3'b100, 3'b100, 8'h33, 1'b0);

    // Reset mid-sequence with a strobe dropped during reset
    do_reset();
    send(8'h23); chk_all("mid_deal", 3'b001, 3'b001, 8'h23, 1'b0);
    send(8'hF0);
    resetn = 1'b0;
    send(8'h23);
    resetn = 1'b1;
    chk_all("mid_reset", 3'b000, 3'b000, 8'h00, 1'b0);
    send(8'h23); chk_all("mid_after", 3'b001, 3'b001, 8'h23, 1'b0);
    @(negedge clk); chk_all("mid_pulse_end", 3'b000, 3'b001, 8'h23, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
